mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It replaces single-cycle fetch-to-writeback with a state machine that sequences the PC, the instruction register, the register file, the ALU operand muxes and the instruction/data memory handshakes. It consumes the opcode from the instruction decoder and the branch-compare result from the ALU, and drives every datapath enable and select.

## Interface
- `MAX_WAIT`, default 15: cycles a memory request may stay unanswered before a bus-error halt (1..255).
- `clk`  in  1  core clock; all state changes on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `opcode_i`  in  7  `instr[6:0]` from the decoder; valid from DECODE onward.
- `br_taken_i`  in  1  ALU branch-compare result; sampled in EXEC.
- `imem_ready_i`  in  1  instruction memory data valid.
- `dmem_ready_i`  in  1  data memory access complete.
- `imem_req_o`  out  1  instruction fetch request.
- `dmem_req_o`  out  1  data memory request.
- `dmem_we_o`  out  1  data memory write (store).
- `ir_we_o`  out  1  latch instruction register.
- `pc_we_o`  out  1  PC update strobe.
- `pc_sel_o`  out  2  0 = pc+4, 1 = pc+imme (branch/jal), 2 = (rs1+imme)&~1 (jalr).
- `alu_a_sel_o`  out  2  0 = rs1, 1 = pc, 2 = zero (lui).
- `alu_b_sel_o`  out  1  0 = rs2, 1 = imme.
- `rf_we_o`  out  1  register file write.
- `wb_sel_o`  out  2  0 = ALU, 1 = load data, 2 = pc+4.
- `state_o`  out  3  current state encoding.
- `retired_o`  out  32  retired-instruction counter.
- `mem_err_o`  out  1  sticky memory-timeout flag.
- `illegal_o`  out  1  sticky illegal-opcode flag (0 when trap disabled).

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; 6 and 7 are unreachable and recover to HALT.
- FETCH: `imem_req_o`=1. On `imem_ready_i`: `ir_we_o`=1 in the same cycle, then go to DECODE.
- DECODE: register read, one cycle, then go to EXEC. All strobes are 0.
- EXEC: the ALU operand selects follow the opcode.
  - R-type: a=0, b=0.
  - I-ALU, load, store, jalr: a=0, b=1.
  - auipc and branch: a=1, b=1.
  - lui: a=2, b=1.
- EXEC transitions:
  - Branch: `pc_we_o`=1, `pc_sel_o`=`br_taken_i`?1:0, then go to FETCH.
  - Load or store: go to MEM.
  - All others: go to WB.
- MEM: `dmem_req_o`=1 and `dmem_we_o`=(store). Hold the ALU selects from EXEC. On `dmem_ready_i`:
  - Load: go to WB.
  - Store: `pc_we_o`=1, `pc_sel_o`=0, then go to FETCH.
- WB: `rf_we_o`=1 and `pc_we_o`=1, then go to FETCH.
  - `wb_sel_o`: load=1; jal/jalr=2; otherwise 0.
  - `pc_sel_o`: jal=1, jalr=2, otherwise 0.
- HALT: all strobes are 0. The block stays in HALT until reset.
- `retired_o` increments by 1 on every cycle with `pc_we_o`=1. It wraps from 0xFFFFFFFF to 0.
- Wait counter (8-bit):
  - Clears on state entry and whenever the awaited ready is high.
  - Increments each FETCH/MEM cycle in which the ready is low.
  - When the counter reaches `MAX_WAIT` with ready still low, the next state is HALT and `mem_err_o` is set to 1.
  - Ready arriving in the same cycle the counter reaches `MAX_WAIT` wins: the access completes normally.
- Strobes and selects are combinational from the registered state, `opcode_i` and `br_taken_i`. Selects not listed for a state are 0.

## Timing
- While `rstn`=0:
  - state=FETCH; counters and flags are 0.
  - All outputs are forced to 0, including `imem_req_o`.
- The first fetch request appears in the first cycle after reset deassertion.
- Cycles per instruction, with zero-wait memory:
  - Branch: 3.
  - R/I-ALU, lui, auipc, jal, jalr, store: 4.
  - Load: 5.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately. No partial write is produced after the reset edge.
- Ready inputs outside the state that awaits them are ignored.

## Configuration
- `TRAP_ILLEGAL_EN` defined:
  - Any opcode outside the nine RV32I base opcodes detected in DECODE forces the next state to HALT.
  - `illegal_o` is set to 1 and stays sticky until reset.
  - The PC is not updated.
- `TRAP_ILLEGAL_EN` undefined:
  - An illegal opcode executes as a NOP: DECODE → WB with `rf_we_o`=0, `pc_we_o`=1, `pc_sel_o`=0.
  - `illegal_o` is tied to 0.

## Test plan
- Reset release, `imem_ready_i`=1 constantly, R-type `add` (0x33) → states 0,1,2,4,0; `rf_we_o`=1 and `pc_we_o`=1 only in the WB cycle; `retired_o`=1.
- Load `lw` (0x03) with `dmem_ready_i` delayed 3 cycles → MEM held 4 cycles with `dmem_req_o`=1 and `dmem_we_o`=0; WB has `wb_sel_o`=1; total 8 cycles.
- Branch (0x63) with `br_taken_i`=1, then again with 0 → `pc_sel_o`=1 and then 0 in EXEC; both take 3 cycles; `rf_we_o` is never asserted.
- `jalr` (0x67) → EXEC has a=0, b=1; WB has `wb_sel_o`=2 and `pc_sel_o`=2.
- `MAX_WAIT`=4, `imem_ready_i` held 0 → HALT after 4 wait cycles; `mem_err_o`=1; all strobes 0 thereafter. Repeat with ready rising in the 4th wait cycle → normal DECODE, `mem_err_o`=0.
- Opcode 0x7F → with `TRAP_ILLEGAL_EN`: HALT and `illegal_o`=1. Without it: 3-cycle NOP with `pc_sel_o`=0 and `retired_o` incremented.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the RV32I datapath.
// Optional macro TRAP_ILLEGAL_EN: illegal opcodes halt the core instead of retiring as NOPs.
module mc_ctrl_fsm #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [6:0]  opcode_i,
    input  logic        br_taken_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic [1:0]  alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic [31:0] retired_o,
    output logic        mem_err_o,
    output logic        illegal_o
);
    // state  | meaning
    // FETCH  | imem request, latch IR on ready
    // DECODE | register read
    // EXEC   | ALU op, branch resolve
    // MEM    | data memory access
    // WB     | register write-back, PC update
    // HALT   | bus error or trapped opcode, wait for reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_RSV6   = 3'd6,
        S_RSV7   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;
    logic [7:0]  w_wait_inc;
    logic [31:0] r_retired;
    logic        r_mem_err;
    logic        w_timeout;

    logic w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_br;
    logic w_is_load, w_is_store, w_is_imm, w_is_reg, w_legal;
    logic [1:0] w_a_sel;
    logic       w_b_sel;

    logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_rf_we;
    logic [1:0] w_pc_sel, w_alu_a, w_wb_sel;
    logic       w_alu_b;

    assign w_is_lui   = (opcode_i == OP_LUI);
    assign w_is_auipc = (opcode_i == OP_AUIPC);
    assign w_is_jal   = (opcode_i == OP_JAL);
    assign w_is_jalr  = (opcode_i == OP_JALR);
    assign w_is_br    = (opcode_i == OP_BRANCH);
    assign w_is_load  = (opcode_i == OP_LOAD);
    assign w_is_store = (opcode_i == OP_STORE);
    assign w_is_imm   = (opcode_i == OP_IMM);
    assign w_is_reg   = (opcode_i == OP_REG);
    assign w_legal    = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_br |
                        w_is_load | w_is_store | w_is_imm | w_is_reg;

    // Operand selects are shared by EXEC and MEM so the address stays stable during the access.
    always_comb begin
        w_a_sel = 2'd0;
        w_b_sel = 1'b0;
        if (w_is_lui) begin
            w_a_sel = 2'd2;
            w_b_sel = 1'b1;
        end else if (w_is_auipc || w_is_br) begin
            w_a_sel = 2'd1;
            w_b_sel = 1'b1;
        end else if (w_is_imm || w_is_load || w_is_store || w_is_jalr) begin
            w_b_sel = 1'b1;
        end
    end

    assign w_wait_inc = r_wait + 8'd1;

`ifdef TRAP_ILLEGAL_EN
    logic r_illegal;
    logic w_illegal_set;
`endif

    always_comb begin
        w_next     = r_state;
        w_timeout  = 1'b0;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_rf_we    = 1'b0;
        w_pc_sel   = 2'd0;
        w_alu_a    = 2'd0;
        w_alu_b    = 1'b0;
        w_wb_sel   = 2'd0;
`ifdef TRAP_ILLEGAL_EN
        w_illegal_set = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready_i) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_wait_inc == LP_MAX_WAIT) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_DECODE: begin
`ifdef TRAP_ILLEGAL_EN
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_illegal_set = 1'b1;
                    w_next        = S_HALT;
                end
`else
                w_next = w_legal ? S_EXEC : S_WB;
`endif
            end
            S_EXEC: begin
                w_alu_a = w_a_sel;
                w_alu_b = w_b_sel;
                if (w_is_br) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = br_taken_i ? 2'd1 : 2'd0;
                    w_next   = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                w_alu_a    = w_a_sel;
                w_alu_b    = w_b_sel;
                if (dmem_ready_i) begin
                    if (w_is_store) begin
                        w_pc_we = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_inc == LP_MAX_WAIT) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_WB: begin
                w_pc_we  = 1'b1;
                w_rf_we  = w_legal;
                w_wb_sel = w_is_load ? 2'd1 : ((w_is_jal || w_is_jalr) ? 2'd2 : 2'd0);
                w_pc_sel = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_FETCH;
            r_wait    <= 8'd0;
            r_retired <= 32'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || !((r_state == S_FETCH) || (r_state == S_MEM)))
                r_wait <= 8'd0;
            else
                r_wait <= w_wait_inc;
            if (w_pc_we)
                r_retired <= r_retired + 32'd1;
            if (w_timeout)
                r_mem_err <= 1'b1;
        end
    end

`ifdef TRAP_ILLEGAL_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_illegal <= 1'b0;
        else if (w_illegal_set)
            r_illegal <= 1'b1;
    end
    assign illegal_o = r_illegal;
`else
    assign illegal_o = 1'b0;
`endif

    // Combinational strobes are masked by reset so nothing leaks out while rstn is low.
    assign imem_req_o  = rstn & w_imem_req;
    assign dmem_req_o  = rstn & w_dmem_req;
    assign dmem_we_o   = rstn & w_dmem_we;
    assign ir_we_o     = rstn & w_ir_we;
    assign pc_we_o     = rstn & w_pc_we;
    assign rf_we_o     = rstn & w_rf_we;
    assign pc_sel_o    = {2{rstn}} & w_pc_sel;
    assign alu_a_sel_o = {2{rstn}} & w_alu_a;
    assign alu_b_sel_o = rstn & w_alu_b;
    assign wb_sel_o    = {2{rstn}} & w_wb_sel;
    assign state_o     = r_state;
    assign retired_o   = r_retired;
    assign mem_err_o   = r_mem_err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm (MAX_WAIT=4); handles builds with and without TRAP_ILLEGAL_EN.
module tb_mc_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [6:0]  opcode = 7'h00;
    logic        br_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_b_sel, mem_err, illegal;
    logic [1:0]  pc_sel, alu_a_sel, wb_sel;
    logic [2:0]  state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MAX_WAIT(4)) dut (
        .clk(clk), .rstn(rstn), .opcode_i(opcode), .br_taken_i(br_taken),
        .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
        .alu_a_sel_o(alu_a_sel), .alu_b_sel_o(alu_b_sel), .rf_we_o(rf_we),
        .wb_sel_o(wb_sel), .state_o(state), .retired_o(retired),
        .mem_err_o(mem_err), .illegal_o(illegal)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [5:0]  strb;   // {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we}
        logic [1:0]  pcs;
        logic [1:0]  as;
        logic        bs;
        logic [1:0]  wbs;
        logic        me;
        logic        il;
        logic [31:0] ret;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad = 0;
    logic [31:0] exp_ret = 0;

    initial begin
        exp_t  e, a;
        string n;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n = nq.pop_front();
                a = '{state, {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we}, pc_sel,
                      alu_a_sel, alu_b_sel, wb_sel, mem_err, illegal, retired};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", n, a, e);
                end
            end
        end
    end

    task automatic step(input string nm, input logic rs, input logic [6:0] op, input logic br,
                        input logic imr, input logic dmr, input logic [2:0] st,
                        input logic [5:0] strb, input logic [1:0] pcs, input logic [1:0] as,
                        input logic bs, input logic [1:0] wbs, input logic me, input logic il);
        exp_t e;
        @(posedge clk);
        #1;
        rstn = rs; opcode = op; br_taken = br; imem_ready = imr; dmem_ready = dmr;
        if (!rs) exp_ret = 0;
        e = '{st, strb, pcs, as, bs, wbs, me, il, exp_ret};
        q.push_back(e);
        nq.push_back(nm);
        if (strb[1]) exp_ret = exp_ret + 1;
    endtask

    // Four-cycle non-memory instruction with zero-wait fetch.
    task automatic alu4(input string nm, input logic [6:0] op, input logic [1:0] as, input logic bs,
                        input logic [1:0] wbs, input logic [1:0] pcs, input logic rfw);
        step({nm, "_F"}, 1, op, 0, 1, 0, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step({nm, "_D"}, 1, op, 0, 1, 0, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
        step({nm, "_E"}, 1, op, 0, 1, 0, 3'd2, 6'b000000, 0, as, bs, 0, 0, 0);
        step({nm, "_W"}, 1, op, 0, 1, 0, 3'd4, {4'b0000, 1'b1, rfw}, pcs, 0, 0, wbs, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step("rst0", 0, 7'h33, 0, 1, 1, 3'd0, 6'b0, 0, 0, 0, 0, 0, 0);
        step("rst1", 0, 7'h33, 0, 1, 1, 3'd0, 6'b0, 0, 0, 0, 0, 0, 0);

        alu4("add", 7'h33, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);

        step("lw_F",  1, 7'h03, 0, 1, 1, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step("lw_D",  1, 7'h03, 0, 1, 1, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
        step("lw_E",  1, 7'h03, 0, 1, 1, 3'd2, 6'b000000, 0, 0, 1, 0, 0, 0);
        step("lw_M1", 1, 7'h03, 0, 1, 0, 3'd3, 6'b010000, 0, 0, 1, 0, 0, 0);
        step("lw_M2", 1, 7'h03, 0, 1, 0, 3'd3, 6'b010000, 0, 0, 1, 0, 0, 0);
        step("lw_M3", 1, 7'h03, 0, 1, 0, 3'd3, 6'b010000, 0, 0, 1, 0, 0, 0);
        step("lw_M4", 1, 7'h03, 0, 1, 1, 3'd3, 6'b010000, 0, 0, 1, 0, 0, 0);
        step("lw_W",  1, 7'h03, 0, 1, 0, 3'd4, 6'b000011, 0, 0, 0, 1, 0, 0);

        step("bt_F", 1, 7'h63, 0, 1, 0, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step("bt_D", 1, 7'h63, 0, 1, 0, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
        step("bt_E", 1, 7'h63, 1, 1, 0, 3'd2, 6'b000010, 1, 1, 1, 0, 0, 0);
        step("bn_F", 1, 7'h63, 1, 1, 0, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step("bn_D", 1, 7'h63, 1, 1, 0, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
        step("bn_E", 1, 7'h63, 0, 1, 0, 3'd2, 6'b000010, 0, 1, 1, 0, 0, 0);

        alu4("jalr",  7'h67, 2'd0, 1'b1, 2'd2, 2'd2, 1'b1);
        alu4("jal",   7'h6F, 2'd0, 1'b0, 2'd2, 2'd1, 1'b1);
        alu4("lui",   7'h37, 2'd2, 1'b1, 2'd0, 2'd0, 1'b1);
        alu4("auipc", 7'h17, 2'd1, 1'b1, 2'd0, 2'd0, 1'b1);

        step("sw_F", 1, 7'h23, 0, 1, 0, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step("sw_D", 1, 7'h23, 0, 1, 0, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
        step("sw_E", 1, 7'h23, 0, 1, 0, 3'd2, 6'b000000, 0, 0, 1, 0, 0, 0);
        step("sw_M", 1, 7'h23, 0, 1, 1, 3'd3, 6'b011010, 0, 0, 1, 0, 0, 0);

        step("fw_F1", 1, 7'h13, 0, 0, 1, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
        step("fw_F2", 1, 7'h13, 0, 0, 1, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
        step("fw_F3", 1, 7'h13, 0, 0, 1, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
        step("fw_F4", 1, 7'h13, 0, 1, 1, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step("fw_D",  1, 7'h13, 0, 1, 0, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
        step("fw_E",  1, 7'h13, 0, 1, 0, 3'd2, 6'b000000, 0, 0, 1, 0, 0, 0);
        step("fw_W",  1, 7'h13, 0, 1, 0, 3'd4, 6'b000011, 0, 0, 0, 0, 0, 0);

        step("ill_F", 1, 7'h7F, 0, 1, 0, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step("ill_D", 1, 7'h7F, 0, 1, 0, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
`ifdef TRAP_ILLEGAL_EN
        step("ill_H1", 1, 7'h7F, 0, 1, 1, 3'd5, 6'b000000, 0, 0, 0, 0, 0, 1);
        step("ill_H2", 1, 7'h7F, 0, 1, 1, 3'd5, 6'b000000, 0, 0, 0, 0, 0, 1);
`else
        step("ill_W", 1, 7'h7F, 0, 1, 0, 3'd4, 6'b000010, 0, 0, 0, 0, 0, 0);
        step("ill_F2", 1, 7'h7F, 0, 0, 0, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
`endif

        step("rst2", 0, 7'h23, 0, 1, 0, 3'd0, 6'b0, 0, 0, 0, 0, 0, 0);
        step("ab_F", 1, 7'h23, 0, 1, 0, 3'd0, 6'b100100, 0, 0, 0, 0, 0, 0);
        step("ab_D", 1, 7'h23, 0, 1, 0, 3'd1, 6'b000000, 0, 0, 0, 0, 0, 0);
        step("ab_E", 1, 7'h23, 0, 1, 0, 3'd2, 6'b000000, 0, 0, 1, 0, 0, 0);
        step("ab_rst", 0, 7'h23, 0, 1, 1, 3'd0, 6'b0, 0, 0, 0, 0, 0, 0);

        step("to_F1", 1, 7'h33, 0, 0, 1, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
        step("to_F2", 1, 7'h33, 0, 0, 1, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
        step("to_F3", 1, 7'h33, 0, 0, 1, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
        step("to_F4", 1, 7'h33, 0, 0, 1, 3'd0, 6'b100000, 0, 0, 0, 0, 0, 0);
        step("to_H1", 1, 7'h33, 0, 1, 1, 3'd5, 6'b000000, 0, 0, 0, 0, 1, 0);
        step("to_H2", 1, 7'h33, 0, 1, 1, 3'd5, 6'b000000, 0, 0, 0, 0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
